// File: rtl/run_monitor.sv
// run_monitor: run controller for the cortex_m0 top level.
// Sequences the core reset, counts RUN cycles, and ends the run on a core
// halt request or (optionally) a watchdog timeout.
// Optional feature macro: RUN_MONITOR_TIMEOUT_EN compiles in the watchdog
// and the TIMED_OUT state; without it, timeout is tied low.
module run_monitor #(
  parameter int CNT_W          = 32,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CODE_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic [CODE_W-1:0] exit_code_in,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CODE_W-1:0] exit_code
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);

  // Catch out-of-range parameters at elaboration rather than at run time
  if (CNT_W < 8 || RST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("run_monitor: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
`ifdef RUN_MONITOR_TIMEOUT_EN
    TIMED_OUT,
`endif
    HALTED
  } state_t;

  state_t            state, state_nxt;
  logic [RC_W-1:0]   rcnt, rcnt_nxt;
  logic [CNT_W-1:0]  cnt_nxt, cnt_inc;
  logic              done_nxt;
  logic [CODE_W-1:0] code_nxt;
  logic              core_rst_nxt, running_nxt;
  logic              can_start;
  logic              wd_hit;

`ifdef RUN_MONITOR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic timeout_nxt;
  assign wd_hit    = (cycle_count == TO_LAST);
  assign can_start = (state == IDLE) || (state == HALTED) || (state == TIMED_OUT);
`else
  assign wd_hit    = 1'b0;
  assign can_start = (state == IDLE) || (state == HALTED);
`endif

  // Saturating increment so a long run pins at all-ones instead of wrapping
  assign cnt_inc = (cycle_count == {CNT_W{1'b1}}) ? cycle_count : cycle_count + 1'b1;

  // State and registered outputs; rst forces the idle/reset values
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rcnt        <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      exit_code   <= '0;
      core_rst    <= 1'b1;
      running     <= 1'b0;
`ifdef RUN_MONITOR_TIMEOUT_EN
      timeout     <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      rcnt        <= rcnt_nxt;
      cycle_count <= cnt_nxt;
      done        <= done_nxt;
      exit_code   <= code_nxt;
      core_rst    <= core_rst_nxt;
      running     <= running_nxt;
`ifdef RUN_MONITOR_TIMEOUT_EN
      timeout     <= timeout_nxt;
`endif
    end
  end

`ifndef RUN_MONITOR_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  // Next state plus the counter, flag and exit-code updates that go with it
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    cnt_nxt   = cycle_count;
    done_nxt  = done;
    code_nxt  = exit_code;
`ifdef RUN_MONITOR_TIMEOUT_EN
    timeout_nxt = timeout;
`endif
    if (can_start) begin
      if (start) begin
        state_nxt = RESET;
        rcnt_nxt  = RC_LOAD;
        cnt_nxt   = '0;
        done_nxt  = 1'b0;
        code_nxt  = '0;
`ifdef RUN_MONITOR_TIMEOUT_EN
        timeout_nxt = 1'b0;
`endif
      end
    end else begin
      case (state)
        RESET: begin
          if (rcnt == '0) begin
            state_nxt = RUN;
          end else begin
            rcnt_nxt = rcnt - 1'b1;
          end
        end
        RUN: begin
          cnt_nxt = cnt_inc;
          if (halt_req) begin
            state_nxt = HALTED;
            done_nxt  = 1'b1;
            code_nxt  = exit_code_in;
          end else if (wd_hit) begin
`ifdef RUN_MONITOR_TIMEOUT_EN
            state_nxt   = TIMED_OUT;
            timeout_nxt = 1'b1;
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Core reset and running are decoded from the next state so they register cleanly
  always_comb begin
    core_rst_nxt = (state_nxt != RUN);
    running_nxt  = (state_nxt == RUN);
  end

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed vector table plus hand-written sequences for run_monitor.
// Instance uses CNT_W=8, RST_CYCLES=4, TIMEOUT_CYCLES=20, CODE_W=8.
module tb_run_monitor;

  logic       clk;
  logic       rst;
  logic       start;
  logic       halt_req;
  logic [7:0] exit_code_in;
  logic       core_rst;
  logic       running;
  logic       done;
  logic       timeout;
  logic [7:0] cycle_count;
  logic [7:0] exit_code;

  int compared;
  int mismatched;

  run_monitor #(
    .CNT_W(8),
    .RST_CYCLES(4),
    .TIMEOUT_CYCLES(20),
    .CODE_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .halt_req(halt_req),
    .exit_code_in(exit_code_in),
    .core_rst(core_rst),
    .running(running),
    .done(done),
    .timeout(timeout),
    .cycle_count(cycle_count),
    .exit_code(exit_code)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic       halt;
    logic [7:0] code;
    logic       eCoreRst;
    logic       eRunning;
    logic       eDone;
    logic       eTimeout;
    logic [7:0] eCnt;
    logic [7:0] eCode;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic r, logic s, logic h, logic [7:0] c,
                              logic ecr, logic er, logic ed, logic et,
                              logic [7:0] ecnt, logic [7:0] ecode);
    vec_t v;
    v.rst = r; v.start = s; v.halt = h; v.code = c;
    v.eCoreRst = ecr; v.eRunning = er; v.eDone = ed; v.eTimeout = et;
    v.eCnt = ecnt; v.eCode = ecode;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ecr, input logic er, input logic ed,
                          input logic et, input logic [7:0] ecnt, input logic [7:0] ecode);
    checkOutput({tag, " core_rst"}, 32'(core_rst), 32'(ecr));
    checkOutput({tag, " running"}, 32'(running), 32'(er));
    checkOutput({tag, " done"}, 32'(done), 32'(ed));
    checkOutput({tag, " timeout"}, 32'(timeout), 32'(et));
    checkOutput({tag, " cycle_count"}, 32'(cycle_count), 32'(ecnt));
    checkOutput({tag, " exit_code"}, 32'(exit_code), 32'(ecode));
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; start = v.start; halt_req = v.halt; exit_code_in = v.code;
    step();
    rst = 1'b0; start = 1'b0; halt_req = 1'b0; exit_code_in = 8'h00;
  endtask

  // Pulse start, then count edges until running rises (bounded)
  task automatic startRun(input string tag);
    int k;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!running && k < 12) begin
      step();
      k++;
    end
    checkOutput({tag, " reset_length"}, 32'(k), 32'd4);
  endtask

  task automatic runEdges(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Safety net so a stuck run still ends
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b0; start = 1'b0; halt_req = 1'b0; exit_code_in = 8'h00;

    //            rst  st   hlt  code   cr   run  dn   to   cnt    code
    vecs[0]  = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,8'd0, 8'h00);
    vecs[1]  = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,8'd0, 8'h00);
    vecs[2]  = mk(1'b0,1'b0,1'b1,8'h33, 1'b1,1'b0,1'b0,1'b0,8'd0, 8'h00);
    vecs[3]  = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,8'd0, 8'h00);
    vecs[4]  = mk(1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,8'd0, 8'h00);
    vecs[5]  = mk(1'b0,1'b0,1'b1,8'h44, 1'b1,1'b0,1'b0,1'b0,8'd0, 8'h00);
    vecs[6]  = mk(1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,8'd0, 8'h00);
    vecs[7]  = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,8'd0, 8'h00);
    vecs[8]  = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,8'd1, 8'h00);
    vecs[9]  = mk(1'b0,1'b1,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,8'd2, 8'h00);
    vecs[10] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,8'd3, 8'h00);
    vecs[11] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,8'd4, 8'h00);
    vecs[12] = mk(1'b0,1'b1,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,8'd5, 8'h00);
    vecs[13] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,8'd6, 8'h00);
    vecs[14] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,8'd7, 8'h00);
    vecs[15] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,8'd8, 8'h00);
    vecs[16] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,8'd9, 8'h00);
    vecs[17] = mk(1'b0,1'b0,1'b1,8'h5A, 1'b1,1'b0,1'b1,1'b0,8'd10,8'h5A);
    vecs[18] = mk(1'b0,1'b0,1'b1,8'h77, 1'b1,1'b0,1'b1,1'b0,8'd10,8'h5A);
    vecs[19] = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,8'd0, 8'h00);

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("v%0d", i), vecs[i].eCoreRst, vecs[i].eRunning, vecs[i].eDone,
               vecs[i].eTimeout, vecs[i].eCnt, vecs[i].eCode);
    end

    // Back to IDLE before the hand-written sequences
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Halt and watchdog on the same edge: halt wins
    startRun("tie");
    runEdges(19);
    checkAll("tie_pre", 1'b0, 1'b1, 1'b0, 1'b0, 8'd19, 8'h00);
    halt_req = 1'b1; exit_code_in = 8'hA5;
    step();
    halt_req = 1'b0; exit_code_in = 8'h00;
    checkAll("tie", 1'b1, 1'b0, 1'b1, 1'b0, 8'd20, 8'hA5);

    // rst on the 5th RUN cycle overrides start and halt_req in that cycle
    startRun("midrst");
    runEdges(4);
    checkAll("midrst_pre", 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 8'h00);
    rst = 1'b1; start = 1'b1; halt_req = 1'b1; exit_code_in = 8'hEE;
    step();
    rst = 1'b0; start = 1'b0; halt_req = 1'b0; exit_code_in = 8'h00;
    checkAll("midrst", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    step();
    checkAll("midrst_idle", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);

`ifdef RUN_MONITOR_TIMEOUT_EN
    // Watchdog fires after the 20th RUN edge and the result holds
    startRun("wdog");
    runEdges(19);
    checkAll("wdog_pre", 1'b0, 1'b1, 1'b0, 1'b0, 8'd19, 8'h00);
    runEdges(1);
    checkAll("wdog", 1'b1, 1'b0, 1'b0, 1'b1, 8'd20, 8'h00);
    halt_req = 1'b1; exit_code_in = 8'h99;
    runEdges(5);
    halt_req = 1'b0; exit_code_in = 8'h00;
    checkAll("wdog_hold", 1'b1, 1'b0, 1'b0, 1'b1, 8'd20, 8'h00);
`else
    // Without the watchdog the count saturates instead of wrapping
    startRun("sat");
    runEdges(300);
    checkAll("sat", 1'b0, 1'b1, 1'b0, 1'b0, 8'd255, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
# run_monitor

Simulation/bring-up run controller for the cortex_m0 top level. It sequences the core reset, counts the cycles the core runs, and ends the run on a core halt request or a watchdog timeout. It latches the exit code and holds the core in reset afterwards. It is the synthesizable successor to the bench's bare 8-bit counter, parametrised in counter width, reset length and timeout, and usable both in benches and on FPGA.

## Interface
Parameters:
- CNT_W, 32, width of the cycle counter (≥ 8).
- RST_CYCLES, 4, number of cycles `core_rst` is held high after a start (≥ 1).
- TIMEOUT_CYCLES, 1000000, watchdog limit in RUN cycles (1 ≤ value ≤ 2^CNT_W − 1).
- CODE_W, 8, width of the exit code.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- rst, in, 1, synchronous, active-high reset.
- start, in, 1, one-cycle request to begin a run.
- halt_req, in, 1, core signals end of program (e.g. write to halt address).
- exit_code_in, in, CODE_W, value sampled with halt_req.
- core_rst, out, 1, reset to cortex_m0 (active-high).
- running, out, 1, high in RUN.
- done, out, 1, sticky; run ended by halt_req.
- timeout, out, 1, sticky; run ended by watchdog.
- cycle_count, out, CNT_W, RUN cycles elapsed.
- exit_code, out, CODE_W, latched exit_code_in.

## Operation
- States: IDLE, RESET, RUN, HALTED, TIMED_OUT. All outputs are registered.
- rst=1, regardless of state → IDLE. core_rst=1, running=0, done=0, timeout=0, cycle_count=0, exit_code=0. Internal reset counter=0.
- IDLE: core_rst=1. start=1 → RESET. The reset counter loads RST_CYCLES−1. cycle_count, done, timeout and exit_code clear.
- RESET: core_rst=1. The counter decrements each cycle. At 0 → RUN.
- RUN: core_rst=0, running=1. cycle_count increments every RUN cycle, including the cycle halt_req is sampled. It saturates at 2^CNT_W−1 and never wraps.
  - halt_req=1 → HALTED. done=1, exit_code←exit_code_in.
  - halt_req=0 and cycle_count==TIMEOUT_CYCLES−1 on this edge, i.e. the count would reach TIMEOUT_CYCLES → TIMED_OUT. timeout=1.
  - halt_req and timeout in the same cycle: halt wins. done=1, timeout=0.
- HALTED / TIMED_OUT: core_rst=1, running=0. cycle_count, exit_code and the flags hold. start=1 → RESET, with the same clearing as from IDLE.
- start is ignored in RESET and RUN. halt_req is ignored outside RUN.
- done and timeout are mutually exclusive.

## Timing
- start sampled at edge N: core_rst stays 1 through edge N+RST_CYCLES and falls after that edge. running rises on the same edge.
- First RUN cycle: cycle_count goes 0→1 at its end.
- halt_req sampled at edge M: done, exit_code and core_rst=1 are visible after edge M. cycle_count includes that cycle.
- Timeout: timeout=1 and cycle_count=TIMEOUT_CYCLES are visible after the TIMEOUT_CYCLES-th RUN edge.
- rst mid-run takes effect on the next edge. It overrides start and halt_req in that same cycle.

## Configuration
- RUN_MONITOR_TIMEOUT_EN defined: the watchdog is compiled in as described above.
- Not defined: the TIMED_OUT state and its comparator are removed. timeout is tied to 0. RUN ends only on halt_req or rst, and cycle_count saturates. TIMEOUT_CYCLES is unused.

## Test plan
- Reset, then check: rst=1 for 2 cycles → core_rst=1, running=0, done=0, timeout=0, cycle_count=0, exit_code=0.
- Reset length: RST_CYCLES=4, start pulsed → core_rst high for exactly 4 edges after start, then running=1.
- Normal halt: halt_req=1 with exit_code_in=8'h5A on the 10th RUN cycle → done=1, exit_code=8'h5A, cycle_count=10, core_rst=1. A later start clears done and cycle_count.
- Timeout (macro on, TIMEOUT_CYCLES=20, no halt) → timeout=1, cycle_count=20, done=0.
- Tie and saturation:
  - halt_req=1 on cycle 20 with TIMEOUT_CYCLES=20 → done=1, timeout=0.
  - With CNT_W=8 and the macro off, run 300 cycles → cycle_count=255.
- Mid-run reset and ignored inputs:
  - rst=1 on RUN cycle 5 → IDLE with all outputs at reset values next cycle.
  - start pulsed during RUN → no effect on cycle_count.
